// File: rtl/prog_delay.sv
// Programmable integer-sample delay line over a circular BRAM buffer.
// The new delay is applied on frame sync. Output latency is a fixed two cycles.
module prog_delay #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  sync_in,
  input  logic [ADDR_WIDTH-1:0] delay_in,
  input  logic                  delay_load,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  sync_out,
  output logic [ADDR_WIDTH-1:0] delay_active,
  output logic                  primed
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] MAX_DELAY = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] pending;
  logic [ADDR_WIDTH-1:0] dly;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] byp;
  logic                  v1;
  logic                  s1;
  logic                  p1;
  logic                  z1;

  assign rd_addr      = wr_ptr - dly;
  assign delay_active = dly;

  // Buffer storage is never reset; unprimed reads are masked instead.
  always_ff @(posedge clk) begin
    if (din_valid && !rst)
      mem[wr_ptr] <= din;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill       <= '0;
      pending    <= '0;
      dly        <= '0;
      v1         <= 1'b0;
      s1         <= 1'b0;
      p1         <= 1'b0;
      z1         <= 1'b0;
      byp        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_out   <= 1'b0;
      primed     <= 1'b0;
    end else begin
      if (din_valid) begin
        wr_ptr <= wr_ptr + ONE;
        if (fill != MAX_DELAY)
          fill <= fill + ONE;
      end
      if (delay_load)
        pending <= delay_in;
      if (sync_in)
        dly <= delay_load ? delay_in : pending;
      v1  <= din_valid;
      s1  <= sync_in;
      p1  <= (fill >= dly);
      z1  <= (dly == '0);
      byp <= din;
      dout_valid <= v1;
      sync_out   <= s1;
      // Output and primed hold across invalid cycles.
      if (v1) begin
        primed <= p1;
        if (!p1)
          dout <= '0;
        else if (z1)
          dout <= byp;
        else
          dout <= rd_data;
      end
    end
  end

endmodule
